// File: rtl/zbus_pkg.sv
// Shared types and constants for the ZX bus initiator: FSM states, cycle-type
// encodings and the extra-wait counter width helper.
package zbus_pkg;

  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, TR} state_t;

  localparam logic CYC_MEM   = 1'b0;
  localparam logic CYC_IO    = 1'b1;
  localparam logic CYC_READ  = 1'b0;
  localparam logic CYC_WRITE = 1'b1;

  localparam int TDIV_DEF     = 4;
  localparam int WAIT_MAX_DEF = 8;

  function automatic int wait_cnt_w(input int wait_max);
    return $clog2(wait_max + 1);
  endfunction

endpackage

// File: rtl/zbus_master_if.sv
// Command/response handshake of the ZX bus initiator.
// cmd: a command transfers on a rising fclk where cmd_valid && cmd_ready; fields
// are don't-care otherwise. rsp: rsp_valid is a single-cycle strobe with no back-pressure.
interface zbus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic        cmd_io;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_iorqge;
  logic        rsp_timeout;

  // master: the bus initiator block; slave: whoever issues commands to it.
  modport master (
    input  cmd_valid, cmd_wr, cmd_io, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_iorqge, rsp_timeout
  );
  modport slave (
    output cmd_valid, cmd_wr, cmd_io, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_iorqge, rsp_timeout
  );
endinterface

// File: rtl/zbus_tstate_timer.sv
// T-state timer: counts fclk cycles inside one bus state and flags the last one.
// Held at zero while idle and wraps on every state boundary.
module zbus_tstate_timer #(
  parameter int TDIV = 4
) (
  input  logic fclk,
  input  logic zrst_n,
  input  logic idle,
  output logic t_last
);
  localparam int CW = (TDIV > 1) ? $clog2(TDIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TDIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge fclk or negedge zrst_n) begin
    if (!zrst_n) begin
      cnt <= '0;
    end else if (idle || t_last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign t_last = !idle && (cnt == CNT_LAST);
endmodule

// File: rtl/zbus_master.sv
// ZX bus initiator: turns one command into a Z80-timed IORQ/MREQ read or write
// cycle (T1 T2 [TW]* T3 TR) and returns a single-cycle response.
module zbus_master
  import zbus_pkg::*;
#(
  parameter int TDIV     = TDIV_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic          fclk,
  input  logic          zrst_n,
  zbus_master_if.master cmd,
  output logic [15:0]   za,
  inout  wire  [7:0]    zd,
  output logic          ziorq_n,
  output logic          zmreq_n,
  output logic          zrd_n,
  output logic          zwr_n,
  input  logic          zwait_n,
  input  logic          ziorqge,
  output state_t        dbg_state
);
  localparam int WCW = wait_cnt_w(WAIT_MAX);
  localparam logic [WCW-1:0] WAIT_LIM = WCW'(WAIT_MAX);

  state_t           state;
  logic             t_last;
  logic             c_wr;
  logic             c_io;
  logic             zd_oe;
  logic [7:0]       zd_out;
  logic [WCW-1:0]   wait_cnt;
  logic [7:0]       rdata_q;
  logic             iorqge_q;
  logic             timeout_q;
  logic             wait_more;
  logic             wait_expired;

  zbus_tstate_timer #(.TDIV(TDIV)) u_timer (
    .fclk   (fclk),
    .zrst_n (zrst_n),
    .idle   (state == IDLE),
    .t_last (t_last)
  );

  // Only meaningful at a wait sample point; the FSM decides when to look.
  assign wait_more    = !zwait_n && (wait_cnt != WAIT_LIM);
  assign wait_expired = !zwait_n && (wait_cnt == WAIT_LIM);

  always_ff @(posedge fclk or negedge zrst_n) begin
    if (!zrst_n) begin
      state     <= IDLE;
      c_wr      <= CYC_READ;
      c_io      <= CYC_MEM;
      za        <= '0;
      zd_oe     <= 1'b0;
      zd_out    <= '0;
      wait_cnt  <= '0;
      ziorq_n   <= 1'b1;
      zmreq_n   <= 1'b1;
      zrd_n     <= 1'b1;
      zwr_n     <= 1'b1;
      rdata_q   <= '0;
      iorqge_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd.cmd_valid && cmd.cmd_ready) begin
            c_wr      <= cmd.cmd_wr;
            c_io      <= cmd.cmd_io;
            za        <= cmd.cmd_addr;
            zd_out    <= cmd.cmd_wdata;
            zd_oe     <= (cmd.cmd_wr == CYC_WRITE);
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
            state     <= T1;
          end
        end
        T1: begin
          if (t_last) begin
            ziorq_n <= (c_io != CYC_IO);
            zmreq_n <= (c_io != CYC_MEM);
            zrd_n   <= (c_wr != CYC_READ);
            zwr_n   <= (c_wr != CYC_WRITE);
            state   <= T2;
          end
        end
        T2: begin
          // IO always takes the mandatory TW; MEM samples the wait line here.
          if (t_last) begin
            if (c_io == CYC_IO) begin
              state <= TW;
            end else if (wait_more) begin
              wait_cnt <= wait_cnt + 1'b1;
              state    <= TW;
            end else begin
              timeout_q <= wait_expired;
              state     <= T3;
            end
          end
        end
        TW: begin
          if (t_last) begin
            if (wait_more) begin
              wait_cnt <= wait_cnt + 1'b1;
            end else begin
              timeout_q <= wait_expired;
              state     <= T3;
            end
          end
        end
        T3: begin
          if (t_last) begin
            rdata_q  <= (c_wr == CYC_WRITE) ? 8'h00 : zd;
            iorqge_q <= ziorqge;
            ziorq_n  <= 1'b1;
            zmreq_n  <= 1'b1;
            zrd_n    <= 1'b1;
            zwr_n    <= 1'b1;
            state    <= TR;
          end
        end
        TR: begin
          if (t_last) begin
            zd_oe <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign zd              = zd_oe ? zd_out : 8'hzz;
  assign cmd.cmd_ready   = zrst_n && (state == IDLE);
  assign cmd.rsp_valid   = (state == TR) && t_last;
  assign cmd.rsp_rdata   = rdata_q;
  assign cmd.rsp_iorqge  = iorqge_q;
  assign cmd.rsp_timeout = timeout_q;
  assign dbg_state       = state;
endmodule

// File: tb/tb_zbus_master.sv
// Directed bench for zbus_master: driver tasks push expected responses, a
// negedge monitor measures strobes/latency/zd and checks them against the queue.
module tb_zbus_master;
  import zbus_pkg::*;

  localparam int TDIV     = 4;
  localparam int WAIT_MAX = 8;

  typedef struct {
    logic        wr;
    logic        io;
    logic [15:0] addr;
    logic [7:0]  rdata;
    logic        iorqge;
    logic        timeout;
    int          lat;
    int          strb;
  } exp_t;

  logic        fclk = 1'b0;
  logic        zrst_n = 1'b0;
  logic [15:0] za;
  wire  [7:0]  zd;
  logic        ziorq_n, zmreq_n, zrd_n, zwr_n;
  logic        zwait_n = 1'b1;
  logic        ziorqge = 1'b0;
  state_t      dbg_state;
  logic [7:0]  resp_data = 8'h00;
  logic        resp_drive;
  logic        chk_gap = 1'b0;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  zbus_master_if bus ();

  zbus_master #(.TDIV(TDIV), .WAIT_MAX(WAIT_MAX)) dut (
    .fclk      (fclk),
    .zrst_n    (zrst_n),
    .cmd       (bus),
    .za        (za),
    .zd        (zd),
    .ziorq_n   (ziorq_n),
    .zmreq_n   (zmreq_n),
    .zrd_n     (zrd_n),
    .zwr_n     (zwr_n),
    .zwait_n   (zwait_n),
    .ziorqge   (ziorqge),
    .dbg_state (dbg_state)
  );

  // clock / reset-free bus keeper: an undriven zd reads 0xFF
  always #5 fclk = ~fclk;
  always @(posedge fclk) cyc <= cyc + 1;

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (zd[i]);
  end

  // responder model: drives read data whenever a read strobe pair is active
  assign resp_drive = !zrd_n && (!zmreq_n || !ziorq_n);
  assign zd = resp_drive ? resp_data : 8'hzz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: call at posedge+#1; returns at posedge+#1 just after the accept edge
  task automatic send(input logic wr, input logic io, input logic [15:0] addr,
                      input logic [7:0] wdata, input logic hold,
                      input logic [7:0] e_rdata, input logic e_iorqge,
                      input logic e_timeout, input int e_lat, input int e_strb);
    exp_t e;
    int   n;
    e.wr = wr; e.io = io; e.addr = addr; e.rdata = e_rdata;
    e.iorqge = e_iorqge; e.timeout = e_timeout; e.lat = e_lat; e.strb = e_strb;
    bus.cmd_wr    = wr;
    bus.cmd_io    = io;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_valid = 1'b1;
    exp_q.push_back(e);
    n = 0;
    while (!bus.cmd_ready && n < 100) begin
      @(posedge fclk); #1;
      n++;
    end
    if (!bus.cmd_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_ready: cmd_ready stayed 0 for %0d cycles, want 1", n);
      void'(exp_q.pop_back());
      bus.cmd_valid = 1'b0;
    end else begin
      @(posedge fclk); #1;
      if (!hold) bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge fclk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: %0d responses outstanding after %0d cycles, want 0", name, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  // scoreboard monitor
  int         acc_cyc = 0;
  int         last_rsp_cyc = -100;
  int         io_low = 0, mem_low = 0, rd_low = 0, wr_low = 0, drv = 0, badv = 0;
  logic [7:0] cur_wd = 8'h00;

  always @(negedge fclk) begin
    exp_t e;
    if (zrst_n) begin
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (chk_gap) check("b2b_accept_gap", cyc - last_rsp_cyc, 1);
        acc_cyc = cyc;
        io_low = 0; mem_low = 0; rd_low = 0; wr_low = 0; drv = 0; badv = 0;
        cur_wd = bus.cmd_wdata;
      end
      if (!ziorq_n) io_low++;
      if (!zmreq_n) mem_low++;
      if (!zrd_n) rd_low++;
      if (!zwr_n) wr_low++;
      if (!resp_drive && zd !== 8'hFF) begin
        drv++;
        if (zd !== cur_wd) badv++;
      end
      vectors++;
      if ((!ziorq_n && !zmreq_n) || (!zrd_n && !zwr_n)) begin
        miscompares++;
        $display("FAIL strobe_excl: iorq_n=%b mreq_n=%b rd_n=%b wr_n=%b, want at most one of each pair low",
                 ziorq_n, zmreq_n, zrd_n, zwr_n);
      end
      if (bus.rsp_valid) begin
        last_rsp_cyc = cyc;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, want no response", cyc);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata",   bus.rsp_rdata,   e.rdata);
          check("rsp_iorqge",  bus.rsp_iorqge,  e.iorqge);
          check("rsp_timeout", bus.rsp_timeout, e.timeout);
          check("latency",     cyc - acc_cyc,   e.lat);
          check("ziorq_low",   io_low,  e.io ? e.strb : 0);
          check("zmreq_low",   mem_low, e.io ? 0 : e.strb);
          check("zrd_low",     rd_low,  e.wr ? 0 : e.strb);
          check("zwr_low",     wr_low,  e.wr ? e.strb : 0);
          check("zd_driven",   drv,     e.wr ? e.lat : 0);
          check("zd_value_bad", badv,   0);
          check("za_held",     za,      e.addr);
        end
      end
    end
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = 1'b0;
    bus.cmd_io    = 1'b0;
    bus.cmd_addr  = 16'h0000;
    bus.cmd_wdata = 8'h00;

    // reset state
    #12;
    check("rst_za",        za, 16'h0000);
    check("rst_strobes",   {ziorq_n, zmreq_n, zrd_n, zwr_n}, 4'b1111);
    check("rst_zd",        zd, 8'hFF);
    check("rst_cmd_ready", bus.cmd_ready, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_fields", {bus.rsp_rdata, bus.rsp_iorqge, bus.rsp_timeout}, 10'h000);
    @(posedge fclk); #1;
    zrst_n = 1'b1;
    @(posedge fclk); #1;
    check("idle_cmd_ready", bus.cmd_ready, 1'b1);

    // IO write: 12 strobe cycles, zd=0x5A T1..TR, latency 20
    send(1'b1, 1'b1, 16'h00AB, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 20, 12);
    wait_done("io_write");

    // MEM read: responder drives 0xC3, latency 16
    resp_data = 8'hC3;
    send(1'b0, 1'b0, 16'h3FFF, 8'h00, 1'b0, 8'hC3, 1'b0, 1'b0, 16, 8);
    wait_done("mem_read");

    // IO read with three extra waits, port occupied
    resp_data = 8'h7E;
    ziorqge   = 1'b1;
    send(1'b0, 1'b1, 16'h1234, 8'h00, 1'b0, 8'h7E, 1'b1, 1'b0, 32, 24);
    zwait_n = 1'b0;
    repeat (21) @(posedge fclk);
    #1;
    zwait_n = 1'b1;
    wait_done("io_read_wait");
    ziorqge = 1'b0;

    // MEM read with wait stuck low: 8 extra TW then forced completion
    resp_data = 8'h11;
    zwait_n   = 1'b0;
    send(1'b0, 1'b0, 16'h8000, 8'h00, 1'b0, 8'h11, 1'b0, 1'b1, 48, 40);
    wait_done("mem_timeout");
    zwait_n = 1'b1;

    // back-to-back with cmd_valid held high
    resp_data = 8'h3C;
    send(1'b1, 1'b0, 16'h4000, 8'hA5, 1'b1, 8'h00, 1'b0, 1'b0, 16, 8);
    chk_gap = 1'b1;
    send(1'b0, 1'b1, 16'h00FE, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 20, 12);
    wait_done("back_to_back");
    chk_gap = 1'b0;

    // async reset in the middle of T3 of an IO write
    send(1'b1, 1'b1, 16'h00CD, 8'h66, 1'b0, 8'h00, 1'b0, 1'b0, 20, 12);
    repeat (13) @(posedge fclk);
    #4;
    zrst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_strobes",   {ziorq_n, zmreq_n, zrd_n, zwr_n}, 4'b1111);
    check("midrst_zd",        zd, 8'hFF);
    check("midrst_cmd_ready", bus.cmd_ready, 1'b0);
    check("midrst_rsp_valid", bus.rsp_valid, 1'b0);
    @(posedge fclk); #3;
    zrst_n = 1'b1;
    #1;
    check("postrst_cmd_ready", bus.cmd_ready, 1'b1);
    check("postrst_state",     dbg_state, IDLE);
    check("postrst_za",        za, 16'h0000);
    repeat (30) @(posedge fclk);
    #1;

    // recovery transaction at the top address
    send(1'b1, 1'b0, 16'hFFFF, 8'h81, 1'b0, 8'h00, 1'b0, 1'b0, 16, 8);
    wait_done("post_reset_write");
    repeat (5) @(posedge fclk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    miscompares++;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/zbus_master.md
Name: zbus_master

Overview:
- Bus-initiator transactor for the ZX bus: the opposite end from the card's zbus responder.
- Converts a simple command handshake into Z80-timed IORQ/MREQ read and write cycles on za/zd/ziorq_n/zmreq_n/zrd_n/zwr_n.
- Samples ziorqge and the read data, and returns a one-cycle response.
- Used as the bring-up host model in the card testbench, and in the FPGA host adapter that exercises the w5300 and sl811 ports.

Parameters:
- TDIV, 4: fclk cycles per Z80 T-state; legal range 2..16.
- WAIT_MAX, 8: maximum extra wait T-states before the cycle is forced to complete with a timeout flag.

Ports:
- fclk  in  1  system clock
- zrst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_wr  in  1  1=write, 0=read
- cmd_io  in  1  1=IORQ cycle, 0=MREQ cycle
- cmd_addr  in  16  bus address
- cmd_wdata  in  8  write data
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  8  read data (0 for writes)
- rsp_iorqge  out  1  ziorqge sampled during T3
- rsp_timeout  out  1  wait exceeded WAIT_MAX
- za  out  16  ZX address bus
- zd  inout  8  ZX data bus; driven only during write cycles
- ziorq_n, zmreq_n, zrd_n, zwr_n  out  1 each  bus strobes, active low
- zwait_n  in  1  bus wait request, active low
- ziorqge  in  1  port-occupied indication from the responder

Behaviour:
- Reset (async, zrst_n=0):
  - All strobes 1; zd tristated; za=0.
  - cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_iorqge=0, rsp_timeout=0.
  - A cycle in flight is abandoned immediately with no response.
- After reset release, the FSM is in IDLE with cmd_ready=1.
- Accept: a command is taken when cmd_valid & cmd_ready. The command fields are registered. cmd_ready drops the next cycle.
- States: IDLE -> T1 -> T2 -> [TW]* -> T3 -> TR -> IDLE.
  - Every non-IDLE state lasts exactly TDIV fclk cycles.
  - Duration is counted by the T-state timer; t_last marks the final fclk of each state.
- T1: za=addr; strobes high; zd driven with wdata if write.
- T2: zmreq_n or ziorq_n asserted (per cmd_io), together with zrd_n or zwr_n (per cmd_wr).
- TW:
  - IO cycles always insert exactly one mandatory TW.
  - MEM cycles insert TW only on a wait request.
- Wait sampling: zwait_n is sampled at t_last of T2 (MEM) or of each TW (IO).
  - If zwait_n=0, another TW follows.
  - An extra-wait counter increments per added TW.
  - When the counter reaches WAIT_MAX, the FSM goes to T3 regardless and sets the timeout flag.
- T3: strobes still asserted. At t_last, zd is captured into rsp_rdata (reads only; writes give 0) and ziorqge into rsp_iorqge.
- TR (recovery):
  - All strobes deasserted at entry.
  - za held; write data held on zd through TR, then tristated on return to IDLE.
  - rsp_valid=1 for the single fclk at t_last of TR; rsp_rdata, rsp_iorqge and rsp_timeout are valid in that cycle.
- IDLE: za keeps its last value; strobes high; cmd_ready=1.
  - Minimum one IDLE cycle between transactions.
  - A command presented during the rsp_valid cycle is not accepted until the following cycle.
- Latency from the accept cycle to rsp_valid, with no waits:
  - IO: 5*TDIV cycles (20 at TDIV=4).
  - MEM: 4*TDIV cycles (16 at TDIV=4).
  - Each added TW adds TDIV.
- Strobe exclusivity:
  - Never more than one of ziorq_n/zmreq_n low.
  - Never both zrd_n and zwr_n low.
  - Strobes never low outside T2..T3.
- cmd_valid while busy is ignored; cmd fields may change freely while cmd_ready=0.
- zwait_n is ignored outside the sample points.

Decomposition:
- Package zbus_pkg holds:
  - state enum {IDLE,T1,T2,TW,T3,TR};
  - the cycle-type constants;
  - WAIT counter width, derived as clog2(WAIT_MAX+1).
- One sub-module, zbus_tstate_timer:
  - mod-TDIV counter, cleared on state change;
  - outputs t_last;
  - same clock and async reset.

Test Plan:
- IO write, TDIV=4, addr=0x00AB, data=0x5A, zwait_n=1 -> ziorq_n/zwr_n low for exactly 12 fclk; zd=0x5A from T1 through TR; rsp_valid 20 cycles after accept; rsp_timeout=0.
- MEM read addr=0x3FFF, responder drives 0xC3 -> zmreq_n/zrd_n low for 8 fclk; rsp_rdata=0xC3; rsp_valid 16 cycles after accept; zd never driven by master.
- IO read, zwait_n held low for 3 TW samples, responder ziorqge=1 -> 3 extra TW (latency 32); rsp_iorqge=1; rsp_timeout=0.
- zwait_n stuck low, WAIT_MAX=8 -> exactly 8 extra TW, then T3; rsp_timeout=1; strobes released in TR.
- Back-to-back commands with cmd_valid held high -> second accept one cycle after the first rsp_valid; no strobe overlap; exclusivity assertions hold throughout.
- zrst_n pulsed low mid-T3 of a write -> strobes high and zd high-Z in the same cycle (async); no rsp_valid; cmd_ready=1 the first cycle after release.
